ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles the PS/2 clock line is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, maximum clk cycles from clock release to ack before abort (20 ms at 50 MHz).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit to the device.
REQ-006 tx_valid  input  1  request; accepted only when tx_ready=1.
REQ-007 tx_ready  output  1  high in IDLE only.
REQ-008 done  output  1  one-cycle pulse: byte sent and device acked.
REQ-009 error  output  1  one-cycle pulse: NACK or timeout; never coincident with done.
REQ-010 ps2_clock  input  1  raw, asynchronous PS/2 clock line state.
REQ-011 ps2_data  input  1  raw, asynchronous PS/2 data line state.
REQ-012 ps2_clock_oe  output  1  1 = pull clock line low; 0 = release.
REQ-013 ps2_data_oe  output  1  1 = pull data line low; 0 = release.

Function
REQ-014 ps2_clock and ps2_data SHALL pass a 2-flop synchronizer; falling edge = previous synced 1, current synced 0.
REQ-015 States: IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: tx_valid=1 latches {odd parity, tx_data} into a 9-bit shift register, loads counter = INHIBIT_CYCLES, goes to INHIBIT; tx_ready low from next cycle.
REQ-017 INHIBIT: ps2_clock_oe=1, data released; counter decrements; at 0, ps2_data_oe=1 (start bit) and go to START.
REQ-018 START: one cycle with both oe=1, then ps2_clock_oe=0, timeout counter loaded with TIMEOUT_CYCLES, go to SEND.
REQ-019 SEND: on each device clock falling edge, drive the next bit LSB-first, data0..7 then parity (ps2_data_oe = NOT bit); 10th falling edge releases data (stop bit), go to ACK.
REQ-020 Parity bit SHALL make the count of ones across data+parity odd.
REQ-021 ACK: on next falling edge sample synced data; 0 = ack, go to WAIT_IDLE; 1 = NACK, pulse error, go to IDLE.
REQ-022 WAIT_IDLE: when both synced lines are 1, pulse done, go to IDLE.
REQ-023 Timeout counter decrements each cycle in SEND, ACK, WAIT_IDLE; at 0 both oe release, error pulses, go to IDLE in the same cycle.
REQ-024 tx_valid while not in IDLE SHALL be ignored; no queuing.
REQ-025 Edges arriving during INHIBIT or START SHALL be ignored.

Reset
REQ-026 reset=1 at a clk edge SHALL force IDLE, tx_ready=1, done=0, error=0, both oe=0, counters and shift register cleared, synchronizers to 1, from any state including mid-byte.

Structure
REQ-027 State encoding and the PS/2 frame length (11 bits) SHALL live in a shared header alongside types.vh, for reuse by the io receiver.
REQ-028 Synchronizer and falling-edge detector SHALL be sub-module ps2_sync_edge, instanced once per line.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocks at 1/40 clk)
REQ-029 Send 0xED -> data_oe per edge 0,1,0,0,1,0,0,0, parity oe 0 (bit 1), stop released; model acks -> done pulse, error 0.
REQ-030 Send 0x00 -> data_oe 1 for all 8 data bits, parity oe 0; clock_oe high exactly 8+1 cycles before release.
REQ-031 Model leaves data high at ack -> error pulse one cycle, no done, tx_ready 1 next cycle.
REQ-032 Model never clocks -> error exactly 2000 cycles after clock release, both oe 0.
REQ-033 Reset asserted after 4th data bit -> next cycle both oe 0, tx_ready 1; new 0xAB then sends correctly.
REQ-034 tx_valid pulsed with 0x55 mid-frame -> ignored; only original byte observed on the line.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host types, frame length and parity helper,
// kept apart so a PS/2 receiver can reuse the same encoding.
package ps2_host_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE} state_t;
    localparam int FRAME_BITS = 11;
    // Zero-based count of device falling edges at which the stop bit is released
    localparam logic [3:0] LAST_SEND_EDGE = 4'(FRAME_BITS - 2);
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for one PS/2 line plus a falling-edge strobe.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clk) begin
        if (reset) {r_meta, r_sync, r_prev} <= 3'b111;
        else {r_meta, r_sync, r_prev} <= {i_line, r_meta, r_sync};
    end
    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data,
// odd parity, stop, device ack) with a release-to-ack timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);
    state_t      r_state, w_next;
    logic [8:0]  r_shift;
    logic [31:0] r_cnt;
    logic [3:0]  r_bitn;
    logic        r_data_oe;
    logic        w_clk_sync, w_clk_fall, w_data_sync, w_unused_data_fall;
    logic        w_active, w_tmo;

    ps2_sync_edge u_clk_sync (
        .clk(clk), .reset(reset), .i_line(ps2_clock), .o_sync(w_clk_sync), .o_fall(w_clk_fall)
    );
    ps2_sync_edge u_data_sync (
        .clk(clk), .reset(reset), .i_line(ps2_data), .o_sync(w_data_sync), .o_fall(w_unused_data_fall)
    );

    // One down-counter serves both the inhibit delay and the ack timeout
    assign w_active = r_state inside {S_SEND, S_ACK, S_WAIT_IDLE};
    assign w_tmo = w_active && r_cnt == '0;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bitn    <= '0;
            r_data_oe <= 1'b0;
        end else begin
            if (r_state == S_IDLE && tx_valid) begin
                r_shift <= {odd_parity(tx_data), tx_data};
                r_cnt   <= 32'(INHIBIT_CYCLES);
            end else if (r_state == S_START) begin
                r_cnt     <= 32'(TIMEOUT_CYCLES);
                r_bitn    <= '0;
                r_data_oe <= 1'b1;
            end else if (r_state != S_IDLE && r_cnt != '0)
                r_cnt <= r_cnt - 32'd1;
            if (r_state == S_SEND && w_clk_fall) begin
                r_data_oe <= (r_bitn < LAST_SEND_EDGE) && !r_shift[0];
                r_shift   <= r_shift >> 1;
                r_bitn    <= r_bitn + 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = tx_valid ? S_INHIBIT : S_IDLE;
            S_INHIBIT:   w_next = (r_cnt <= 32'd1) ? S_START : S_INHIBIT;
            S_START:     w_next = S_SEND;
            S_SEND:      w_next = w_tmo ? S_IDLE : (w_clk_fall && r_bitn == LAST_SEND_EDGE) ? S_ACK : S_SEND;
            S_ACK:       w_next = (w_tmo || (w_clk_fall && w_data_sync)) ? S_IDLE : w_clk_fall ? S_WAIT_IDLE : S_ACK;
            S_WAIT_IDLE: w_next = (w_tmo || (w_clk_sync && w_data_sync)) ? S_IDLE : S_WAIT_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_ready     = r_state == S_IDLE;
        ps2_clock_oe = r_state inside {S_INHIBIT, S_START};
        ps2_data_oe  = r_state == S_START || (r_state == S_SEND && r_data_oe && !w_tmo);
        error        = w_tmo || (r_state == S_ACK && w_clk_fall && w_data_sync);
        done         = r_state == S_WAIT_IDLE && !w_tmo && w_clk_sync && w_data_sync;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table vectors, corner sequences and random bytes against a PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 8, TMO = 2000, HALF = 20;

    typedef struct {
        logic [7:0] d;
        int         mode;
        int         poke;
        logic [9:0] exp_oe;
        int         exp_done;
        int         exp_err;
    } vec_t;

    logic       clk = 0, reset = 1;
    logic [7:0] tx_data = 0;
    logic       tx_valid = 0;
    logic       tx_ready, done, error, ps2_clock_oe, ps2_data_oe;
    logic       dev_clk = 1, dev_data = 1;
    logic       ps2_clock, ps2_data;
    int         checks = 0, errors = 0, cyc = 0, n_done = 0, n_err = 0, err_cyc = 0, rel_cyc = 0;
    logic [1:0] err_oe = 0;
    logic       err_prev = 0;

    assign ps2_clock = dev_clk & ~ps2_clock_oe;
    assign ps2_data  = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .done(done), .error(error), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected data_oe per device falling edge: 8 data LSB-first, parity, released stop
    function automatic logic [9:0] model_oe(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2) == 0;
        return {1'b0, ~par, ~d};
    endfunction

    always @(negedge clk) begin
        if (err_prev) chk("ready_after_error", 32'(tx_ready), 1);
        if (done || error) chk("done_error_exclusive", 32'(done && error), 0);
        err_prev <= error;
        if (done) n_done <= n_done + 1;
        if (error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
            err_oe  <= {ps2_clock_oe, ps2_data_oe};
        end
    end

    // mode 0 = device acks, 1 = device nacks, 2 = device never clocks
    task automatic frame(input logic [7:0] d, input int mode, input int poke, input int abort,
                         output logic [9:0] oe, output int hi);
        int  t;
        bit  stop;
        oe = '0; hi = 0; t = 0; stop = 0;
        tx_data = d; tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        while (ps2_clock_oe && t < 100) begin
            hi++; t++;
            @(negedge clk);
        end
        rel_cyc = cyc;
        chk("start_bit", 32'(ps2_data_oe), 1);
        if (mode != 2) begin
            for (int k = 1; k <= 11 && !stop; k++) begin
                if (k == 11) dev_data = (mode == 1);
                repeat (HALF) @(negedge clk);
                dev_clk = 0;
                repeat (HALF) @(negedge clk);
                if (k <= 10) oe[k-1] = ps2_data_oe;
                if (k == poke) begin
                    tx_data = 8'h55; tx_valid = 1;
                    @(negedge clk);
                    tx_valid = 0;
                end
                if (k == abort) begin
                    reset = 1;
                    @(negedge clk);
                    chk("abort_oe", 32'({ps2_clock_oe, ps2_data_oe}), 0);
                    chk("abort_ready", 32'(tx_ready), 1);
                    reset = 0;
                    stop = 1;
                end
                dev_clk = 1;
                if (k == 11) dev_data = 1;
            end
            repeat (HALF) @(negedge clk);
        end
    endtask

    initial begin
        vec_t       vt[6];
        logic [9:0] oe;
        logic [7:0] d;
        int         hi, d0, e0, t, mode;
        vt[0] = '{8'hED, 0, 0, 10'h012, 1, 0};
        vt[1] = '{8'h00, 0, 0, 10'h0FF, 1, 0};
        vt[2] = '{8'hFF, 0, 0, 10'h000, 1, 0};
        vt[3] = '{8'h01, 0, 0, 10'h1FE, 1, 0};
        vt[4] = '{8'h80, 1, 0, 10'h17F, 0, 1};
        vt[5] = '{8'h3C, 0, 5, 10'h0C3, 1, 0};
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(tx_ready), 1);
        chk("reset_done_error", 32'({done, error}), 0);
        chk("reset_oe", 32'({ps2_clock_oe, ps2_data_oe}), 0);
        reset = 0;
        @(negedge clk);

        foreach (vt[i]) begin
            d0 = n_done; e0 = n_err;
            frame(vt[i].d, vt[i].mode, vt[i].poke, 0, oe, hi);
            chk("clock_hold", hi, INH + 1);
            chk("frame_oe", 32'(oe), 32'(vt[i].exp_oe));
            chk("done_count", n_done - d0, vt[i].exp_done);
            chk("error_count", n_err - e0, vt[i].exp_err);
            chk("ready_end", 32'(tx_ready), 1);
            if (vt[i].poke != 0) begin
                repeat (HALF) @(negedge clk);
                chk("no_queue", 32'(ps2_clock_oe), 0);
            end
        end

        e0 = n_err; d0 = n_done;
        frame(8'hA5, 2, 0, 0, oe, hi);
        t = 0;
        while (n_err == e0 && t < TMO + 200) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_seen", n_err - e0, 1);
        chk("timeout_latency", err_cyc - rel_cyc, TMO);
        chk("timeout_oe", 32'(err_oe), 0);
        chk("timeout_no_done", n_done - d0, 0);
        repeat (3) @(negedge clk);

        d0 = n_done; e0 = n_err;
        frame(8'hC7, 0, 0, 4, oe, hi);
        repeat (HALF) @(negedge clk);
        chk("abort_no_pulse", (n_done - d0) + (n_err - e0), 0);
        d0 = n_done;
        frame(8'hAB, 0, 0, 0, oe, hi);
        chk("after_abort_oe", 32'(oe), 32'(model_oe(8'hAB)));
        chk("after_abort_done", n_done - d0, 1);

        for (int r = 0; r < 20; r++) begin
            d = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            d0 = n_done; e0 = n_err;
            frame(d, mode, 0, 0, oe, hi);
            chk("rand_clock_hold", hi, INH + 1);
            chk("rand_oe", 32'(oe), 32'(model_oe(d)));
            chk("rand_done", n_done - d0, mode == 0 ? 1 : 0);
            chk("rand_error", n_err - e0, mode == 1 ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
